// File: rtl/hazard_scoreboard_if.sv
// Purpose : ID-stage hazard interface between the decode stage and the
//           latency scoreboard, carrying source/destination info in and the
//           stall/issue/hazard decisions plus the stall counter out.
// Ports   : master = ID stage (drives id_*, flush), slave = scoreboard.
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 16
) ();
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [ADDR_W-1:0] id_rd;
    logic              id_reg_write;
    logic [LAT_W-1:0]  id_lat;
    logic              flush;
    logic              stall;
    logic              issue;
    logic              haz_rs1;
    logic              haz_rs2;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_lat, flush,
        input  stall, issue, haz_rs1, haz_rs2, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_lat, flush,
        output stall, issue, haz_rs1, haz_rs2, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Purpose : per-register pending-latency scoreboard; stalls an ID-stage
//           consumer while any source it reads still has bubbles outstanding.
// Latency : stall/issue/haz_* are combinational from ID inputs and counter
//           state; counters and stall_count update on the rising clk edge.
// Backpressure: stall holds PC/IF-ID; flush overrides stall and kills issue.
// Ports   : clk, rst_n (async active-low), sb = slave side of the ID interface.
module hazard_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_scoreboard_if.slave   sb
);
    localparam int NREG = 2 ** ADDR_W;

    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    logic haz_rs1;
    logic haz_rs2;
    logic stall;
    logic issue;
    logic wr_en;

    // Hazard check reads counters before this cycle's update, so an
    // instruction reading and writing the same register never self-stalls.
    always_comb begin
        haz_rs1 = sb.id_valid & sb.id_use_rs1 & (sb.id_rs1 != '0) &
                  (cnt_q[sb.id_rs1] != '0);
        haz_rs2 = sb.id_valid & sb.id_use_rs2 & (sb.id_rs2 != '0) &
                  (cnt_q[sb.id_rs2] != '0);
        stall   = (haz_rs1 | haz_rs2) & ~sb.flush;
        issue   = sb.id_valid & ~stall & ~sb.flush;
        wr_en   = issue & sb.id_reg_write & (sb.id_rd != '0) &
                  (sb.id_lat != '0);
    end

    // Every pending counter ages by one; a new producer raises its
    // destination only if it outlasts what is already pending (WAW).
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
            if (wr_en && (sb.id_rd == ADDR_W'(r)) && (cnt_d[r] < sb.id_lat)) begin
                cnt_d[r] = sb.id_lat;
            end
        end
        // x0 is never tracked.
        cnt_d[0] = '0;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign sb.stall       = stall;
    assign sb.issue       = issue;
    assign sb.haz_rs1     = haz_rs1;
    assign sb.haz_rs2     = haz_rs2;
    assign sb.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    logic clk;
    logic rst_n;

    hazard_scoreboard_if #(.ADDR_W(5), .LAT_W(3), .CNT_W(16)) sb_if ();
    hazard_scoreboard_if #(.ADDR_W(5), .LAT_W(3), .CNT_W(2))  sb_if2 ();

    hazard_scoreboard #(.ADDR_W(5), .LAT_W(3), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    hazard_scoreboard #(.ADDR_W(5), .LAT_W(3), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if2)
    );

    // Saturation instance mirrors the main stimulus.
    assign sb_if2.id_valid     = sb_if.id_valid;
    assign sb_if2.id_rs1       = sb_if.id_rs1;
    assign sb_if2.id_rs2       = sb_if.id_rs2;
    assign sb_if2.id_use_rs1   = sb_if.id_use_rs1;
    assign sb_if2.id_use_rs2   = sb_if.id_use_rs2;
    assign sb_if2.id_rd        = sb_if.id_rd;
    assign sb_if2.id_reg_write = sb_if.id_reg_write;
    assign sb_if2.id_lat       = sb_if.id_lat;
    assign sb_if2.flush        = sb_if.flush;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       use1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       rw;
        logic [2:0] lat;
        logic       fl;
        logic       e_stall;
        logic       e_issue;
        logic       e_h1;
        logic       e_h2;
        int         e_cnt;
    } vec_t;

    vec_t tbl [33];
    vec_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic v, input int r1, input logic u1,
                                input int r2, input logic u2, input int rd,
                                input logic rw, input int lat, input logic fl,
                                input logic es, input logic ei, input logic eh1,
                                input logic eh2, input int ec);
        vec_t t;
        t.valid = v;  t.rs1 = 5'(r1); t.use1 = u1; t.rs2 = 5'(r2); t.use2 = u2;
        t.rd = 5'(rd); t.rw = rw; t.lat = 3'(lat); t.fl = fl;
        t.e_stall = es; t.e_issue = ei; t.e_h1 = eh1; t.e_h2 = eh2; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one ID-stage cycle, queue its expectation, compare mid-cycle,
    // then advance past the rising edge.
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        sb_if.id_valid     = v.valid;
        sb_if.id_rs1       = v.rs1;
        sb_if.id_use_rs1   = v.use1;
        sb_if.id_rs2       = v.rs2;
        sb_if.id_use_rs2   = v.use2;
        sb_if.id_rd        = v.rd;
        sb_if.id_reg_write = v.rw;
        sb_if.id_lat       = v.lat;
        sb_if.flush        = v.fl;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, ".stall"},   int'(sb_if.stall),       int'(e.e_stall));
        chk({tag, ".issue"},   int'(sb_if.issue),       int'(e.e_issue));
        chk({tag, ".haz_rs1"}, int'(sb_if.haz_rs1),     int'(e.e_h1));
        chk({tag, ".haz_rs2"}, int'(sb_if.haz_rs2),     int'(e.e_h2));
        chk({tag, ".count"},   int'(sb_if.stall_count), e.e_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // load-use, lat=1
        tbl[0]  = mk(1, 1,1, 2,1, 5,1,1,0,  0,1,0,0, 0);
        tbl[1]  = mk(1, 5,1, 0,0, 6,1,0,0,  1,0,1,0, 0);
        tbl[2]  = mk(1, 5,1, 0,0, 6,1,0,0,  0,1,0,0, 1);
        // long latency lat=4 on rs2
        tbl[3]  = mk(1, 0,0, 0,0, 7,1,4,0,  0,1,0,0, 1);
        tbl[4]  = mk(1, 0,0, 7,1, 0,0,0,0,  1,0,0,1, 1);
        tbl[5]  = mk(1, 0,0, 7,1, 0,0,0,0,  1,0,0,1, 2);
        tbl[6]  = mk(1, 0,0, 7,1, 0,0,0,0,  1,0,0,1, 3);
        tbl[7]  = mk(1, 0,0, 7,1, 0,0,0,0,  1,0,0,1, 4);
        tbl[8]  = mk(1, 0,0, 7,1, 0,0,0,0,  0,1,0,0, 5);
        // x0 producer/consumer, unused source
        tbl[9]  = mk(1, 0,0, 0,0, 0,1,3,0,  0,1,0,0, 5);
        tbl[10] = mk(1, 0,1, 0,0, 0,0,0,0,  0,1,0,0, 5);
        tbl[11] = mk(1, 0,0, 0,0, 3,1,2,0,  0,1,0,0, 5);
        tbl[12] = mk(1, 3,0, 0,0, 0,0,0,0,  0,1,0,0, 5);
        // read+write same reg: no self stall, then true dependency
        tbl[13] = mk(1,11,1, 0,0,11,1,2,0,  0,1,0,0, 5);
        tbl[14] = mk(1,11,1, 0,0,11,1,2,0,  1,0,1,0, 5);
        tbl[15] = mk(1,11,1, 0,0,11,1,2,0,  1,0,1,0, 6);
        tbl[16] = mk(1,11,1, 0,0,11,1,2,0,  0,1,0,0, 7);
        tbl[17] = mk(0,11,1, 0,0, 0,0,0,0,  0,0,0,0, 7);
        tbl[18] = mk(0,11,1, 0,0, 0,0,0,0,  0,0,0,0, 7);
        // WAW: lat 5 then lat 1 -> longer wins (4 left)
        tbl[19] = mk(1, 0,0, 0,0, 9,1,5,0,  0,1,0,0, 7);
        tbl[20] = mk(1, 0,0, 0,0, 9,1,1,0,  0,1,0,0, 7);
        tbl[21] = mk(1, 9,1, 0,0, 0,0,0,0,  1,0,1,0, 7);
        tbl[22] = mk(1, 9,1, 0,0, 0,0,0,0,  1,0,1,0, 8);
        tbl[23] = mk(1, 9,1, 0,0, 0,0,0,0,  1,0,1,0, 9);
        tbl[24] = mk(1, 9,1, 0,0, 0,0,0,0,  1,0,1,0, 10);
        tbl[25] = mk(1, 9,1, 0,0, 0,0,0,0,  0,1,0,0, 11);
        // flush during stall: counter keeps aging 3,2,1,0
        tbl[26] = mk(1, 0,0, 0,0, 4,1,3,0,  0,1,0,0, 11);
        tbl[27] = mk(1, 4,1, 0,0, 0,0,0,0,  1,0,1,0, 11);
        tbl[28] = mk(1, 4,1, 0,0, 0,0,0,1,  0,0,1,0, 12);
        tbl[29] = mk(1, 4,1, 0,0, 0,0,0,0,  1,0,1,0, 12);
        tbl[30] = mk(1, 4,1, 0,0, 0,0,0,0,  0,1,0,0, 13);
        // flushed producer must not be tracked
        tbl[31] = mk(1, 0,0, 0,0,12,1,3,1,  0,0,0,0, 13);
        tbl[32] = mk(1,12,1, 0,0, 0,0,0,0,  0,1,0,0, 13);

        rst_n = 1'b0;
        step("reset", mk(1, 5,1, 0,0, 5,1,1,0,  0,1,0,0, 0));
        chk("reset.sat_count", int'(sb_if2.stall_count), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 33; i++) begin
            step($sformatf("v%0d", i), tbl[i]);
        end

        // 13 stall cycles so far: 2-bit counter pins at 3
        chk("sat.count", int'(sb_if2.stall_count), 3);

        // async reset in the middle of a lat=6 stall
        step("rst_prod", mk(1, 0,0, 0,0, 6,1,6,0,  0,1,0,0, 13));
        step("rst_cons", mk(1, 6,1, 0,0, 0,0,0,0,  1,0,1,0, 13));
        #2;
        chk("pre_rst.stall", int'(sb_if.stall), 1);
        chk("pre_rst.count", int'(sb_if.stall_count), 14);
        rst_n = 1'b0;
        #1;
        chk("async_rst.stall",     int'(sb_if.stall), 0);
        chk("async_rst.haz_rs1",   int'(sb_if.haz_rs1), 0);
        chk("async_rst.count",     int'(sb_if.stall_count), 0);
        chk("async_rst.sat_count", int'(sb_if2.stall_count), 0);
        #1;
        rst_n = 1'b1;
        step("post_rst",   mk(1, 6,1, 0,0, 0,0,0,0,  0,1,0,0, 0));
        step("first_prod", mk(1, 0,0, 0,0, 8,1,1,0,  0,1,0,0, 0));
        step("first_cons", mk(1, 8,1, 0,0, 0,0,0,0,  1,0,1,0, 0));
        step("first_iss",  mk(1, 8,1, 0,0, 0,0,0,0,  0,1,0,0, 1));

        if (exp_q.size() != 0) begin
            chk("queue.drained", exp_q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5: register-address width; the register file has 2**ADDR_W entries.
REQ-002 Parameter LAT_W, default 3: width of a per-register pending-latency counter; maximum latency is 2**LAT_W-1.
REQ-003 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1: reset, asynchronous, active-low.
REQ-006 id_valid  in  1: a valid instruction occupies the ID stage.
REQ-007 id_rs1 / id_rs2  in  ADDR_W each: source register addresses in ID.
REQ-008 id_use_rs1 / id_use_rs2  in  1 each: the ID instruction actually reads that source.
REQ-009 id_rd  in  ADDR_W: destination of the ID instruction.
REQ-010 id_reg_write  in  1: the ID instruction writes id_rd.
REQ-011 id_lat  in  LAT_W: number of bubbles a dependent consumer needs (0 = fully forwardable; 1 = classic load-use).
REQ-012 flush  in  1: kill the ID instruction this cycle (branch redirect).
REQ-013 stall  out  1: hold PC and IF/ID, insert a bubble into EX.
REQ-014 issue  out  1: the ID instruction advances to EX this cycle.
REQ-015 haz_rs1 / haz_rs2  out  1 each: per-source hazard indication.
REQ-016 stall_count  out  CNT_W: saturating count of stall cycles.

Function
REQ-017 The block SHALL hold one LAT_W-bit counter cnt[r] per register; register 0 has no counter and always reads as 0.
REQ-018 haz_rsN SHALL be id_valid & id_use_rsN & (id_rsN != 0) & (cnt[id_rsN] != 0), combinationally.
REQ-019 stall SHALL be (haz_rs1 | haz_rs2) & ~flush; flush overrides stall.
REQ-020 issue SHALL be id_valid & ~stall & ~flush.
REQ-021 Each cycle, every non-zero counter SHALL decrement by 1; zero counters stay 0, with no wrap-around.
REQ-022 On issue with id_reg_write=1, id_rd!=0, id_lat!=0: cnt[id_rd] next SHALL be max(cnt[id_rd] after decrement, id_lat) (WAW: the longer pending write wins).
REQ-023 An issue with id_lat=0, id_reg_write=0, or id_rd=0 SHALL leave cnt[id_rd] to normal decrement.
REQ-024 A producer issued at cycle t with latency L SHALL stall an immediately following dependent consumer for exactly L cycles (cycles t+1 .. t+L); the consumer issues at t+L+1.
REQ-025 A consumer's own issue and its hazard check use cnt values before the same-cycle update (same-register read/write in one instruction does not self-stall).
REQ-026 flush SHALL NOT clear counters: older in-flight producers remain tracked.
REQ-027 stall_count SHALL increment by 1 on each cycle with stall=1 and saturate at 2**CNT_W-1.
REQ-028 With all id_lat inputs tied to 1 for loads and 0 otherwise, behaviour SHALL equal a single-bubble load-use detector.

Reset
REQ-029 While rst_n=0, all cnt[r] and stall_count SHALL be 0 immediately, independent of clk.
REQ-030 Reset asserted mid-stall SHALL drop stall to 0 in the same cycle (counters cleared); stall remains 0 after release until a new producer issues.
REQ-031 The first rising edge after rst_n rises SHALL be a normal operating edge.

Verification
REQ-032 Load-use: issue rd=5, lat=1; next ID rs1=5 use=1 -> stall=1 for one cycle, issue=1 on the following cycle, stall_count=1.
REQ-033 Long latency: issue rd=7, lat=4; consumer rs2=7 right behind -> stall high 4 cycles, stall_count=4, then issue.
REQ-034 x0 and unused source: producer rd=0, lat=3 then rs1=0; also producer rd=3, lat=2 with consumer id_use_rs1=0, rs1=3 -> stall=0 in both cases.
REQ-035 WAW merge: issue rd=9 lat=5, next cycle issue rd=9 lat=1 -> cnt[9]=4 after the second issue; consumer of x9 stalls until cnt reaches 0.
REQ-036 Flush during stall: pending rd=4 lat=3, consumer stalled, flush=1 -> stall=0, issue=0, cnt[4] keeps decrementing (2, 1, 0).
REQ-037 Reset mid-stall plus saturation: drive rst_n=0 during a lat=6 stall -> stall=0 and stall_count=0 asynchronously; with CNT_W=2, 5 stall cycles -> stall_count=3.
